// File: rtl/vx_cache_flush_ctrl_if.sv
// vx_cache_flush_ctrl_if: handshake bundle between the flush sequencer and its bank
// master (the sequencer) drives: flush_req_ready, flush_done, core_req_block, init,
//   init_line, flush_valid, flush_line_sel, flush_way_sel, busy
// slave (the bank/core side) drives: flush_req_valid, mshr_empty, flush_ready,
//   evict_fire, mem_wr_ack
interface vx_cache_flush_ctrl_if #(
  parameter int NUM_WAYS      = 4,
  parameter int LINE_SEL_BITS = 6
);
  logic                     flush_req_valid;
  logic                     flush_req_ready;
  logic                     flush_done;
  logic                     mshr_empty;
  logic                     core_req_block;
  logic                     init;
  logic [LINE_SEL_BITS-1:0] init_line;
  logic                     flush_valid;
  logic                     flush_ready;
  logic [LINE_SEL_BITS-1:0] flush_line_sel;
  logic [NUM_WAYS-1:0]      flush_way_sel;
  logic                     evict_fire;
  logic                     mem_wr_ack;
  logic                     busy;
  modport master (
    input  flush_req_valid, mshr_empty, flush_ready, evict_fire, mem_wr_ack,
    output flush_req_ready, flush_done, core_req_block, init, init_line,
           flush_valid, flush_line_sel, flush_way_sel, busy
  );
  modport slave (
    output flush_req_valid, mshr_empty, flush_ready, evict_fire, mem_wr_ack,
    input  flush_req_ready, flush_done, core_req_block, init, init_line,
           flush_valid, flush_line_sel, flush_way_sel, busy
  );
endinterface

// File: rtl/vx_cache_flush_ctrl.sv
// vx_cache_flush_ctrl: per-bank tag init sweep and flush/write-back sequencer
// clk, reset    : clock, synchronous active-high reset
// bus (master)  : flush request/done, drain, init and flush command handshakes,
//                 eviction/ack pulses, busy and core stall
// VX_CACHE_FLUSH_PERF_EN adds perf_flush_evicts / perf_flush_cycles (32-bit, saturating)
module vx_cache_flush_ctrl #(
  parameter int NUM_WAYS       = 4,
  parameter int LINES_PER_BANK = 64,
  parameter int LINE_SEL_BITS  = $clog2(LINES_PER_BANK),
  parameter int MAX_PENDING    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_cache_flush_ctrl_if.master bus
`ifdef VX_CACHE_FLUSH_PERF_EN
  ,
  output logic [31:0]          perf_flush_evicts,
  output logic [31:0]          perf_flush_cycles
`endif
);
  localparam int WAY_BITS  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  localparam int PEND_BITS = $clog2(MAX_PENDING + 1);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_DRAIN, S_FLUSH, S_WAIT_WB, S_DONE} state_t;
  state_t                   r_state, w_state_nxt;
  logic [LINE_SEL_BITS-1:0] r_line, w_line_nxt;
  logic [WAY_BITS-1:0]      r_way, w_way_nxt;
  logic [PEND_BITS-1:0]     r_pend, w_pend_nxt;
  logic                     w_flush_valid, w_fire, w_last_line, w_last_way;
  assign w_last_line   = r_line == LINE_SEL_BITS'(LINES_PER_BANK - 1);
  // with a single way this is always true, so way_ctr never leaves 0
  assign w_last_way    = r_way == WAY_BITS'(NUM_WAYS - 1);
  assign w_flush_valid = (r_state == S_FLUSH) && (r_pend != PEND_BITS'(MAX_PENDING));
  assign w_fire        = w_flush_valid & bus.flush_ready;
  assign w_pend_nxt    = bus.evict_fire == bus.mem_wr_ack ? r_pend :
                         bus.evict_fire ? r_pend + 1'b1 : r_pend - 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_line  <= '0;
      r_way   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_way   <= w_way_nxt;
      r_pend  <= w_pend_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_way_nxt   = r_way;
    case (r_state)
      S_INIT: begin
        w_line_nxt  = w_last_line ? '0 : r_line + 1'b1;
        w_state_nxt = w_last_line ? S_IDLE : S_INIT;
      end
      S_IDLE:    w_state_nxt = bus.flush_req_valid ? S_DRAIN : S_IDLE;
      S_DRAIN:   w_state_nxt = bus.mshr_empty ? S_FLUSH : S_DRAIN;
      S_FLUSH: begin
        // line-major walk; both counters wrap to 0 on the final fire
        w_way_nxt   = w_fire ? (w_last_way ? '0 : r_way + 1'b1) : r_way;
        w_line_nxt  = w_fire && w_last_way ? (w_last_line ? '0 : r_line + 1'b1) : r_line;
        w_state_nxt = w_fire && w_last_way && w_last_line ? S_WAIT_WB : S_FLUSH;
      end
      S_WAIT_WB: w_state_nxt = r_pend == '0 ? S_DONE : S_WAIT_WB;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_INIT;
    endcase
  end
  assign bus.flush_req_ready = r_state == S_IDLE;
  assign bus.flush_done      = r_state == S_DONE;
  assign bus.core_req_block  = r_state inside {S_INIT, S_DRAIN, S_FLUSH, S_WAIT_WB};
  assign bus.busy            = r_state != S_IDLE;
  assign bus.init            = r_state == S_INIT;
  assign bus.init_line       = r_state == S_INIT ? r_line : '0;
  assign bus.flush_valid     = w_flush_valid;
  assign bus.flush_line_sel  = r_state == S_FLUSH ? r_line : '0;
  assign bus.flush_way_sel   = r_state == S_FLUSH ? NUM_WAYS'(1) << r_way : '0;
  a_pend_overflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.evict_fire && !bus.mem_wr_ack && r_pend == PEND_BITS'(MAX_PENDING)));
  a_pend_underflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.mem_wr_ack && !bus.evict_fire && r_pend == '0));
`ifdef VX_CACHE_FLUSH_PERF_EN
  logic [31:0] r_perf_evicts, r_perf_cycles;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_evicts <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (bus.evict_fire && r_state inside {S_FLUSH, S_WAIT_WB} && !(&r_perf_evicts))
        r_perf_evicts <= r_perf_evicts + 32'd1;
      if (r_state inside {S_DRAIN, S_FLUSH, S_WAIT_WB, S_DONE} && !(&r_perf_cycles))
        r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end
  assign perf_flush_evicts = r_perf_evicts;
  assign perf_flush_cycles = r_perf_cycles;
`endif
endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// tb_vx_cache_flush_ctrl: randomized self-checking bench with a queue/counter reference model
module tb_vx_cache_flush_ctrl;
  localparam int NW = 2, LPB = 4, LSB = 2, MAXP = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0, n_fail = 0, pend = 0;
  always #5 clk = ~clk;
  vx_cache_flush_ctrl_if #(.NUM_WAYS(NW), .LINE_SEL_BITS(LSB)) sif();
  vx_cache_flush_ctrl_if big();
`ifdef VX_CACHE_FLUSH_PERF_EN
  logic [31:0] pe_s, pc_s, pe_b, pc_b;
`endif
  vx_cache_flush_ctrl #(.NUM_WAYS(NW), .LINES_PER_BANK(LPB), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset), .bus(sif)
`ifdef VX_CACHE_FLUSH_PERF_EN
    , .perf_flush_evicts(pe_s), .perf_flush_cycles(pc_s)
`endif
  );
  vx_cache_flush_ctrl u_big (
    .clk(clk), .reset(reset), .bus(big)
`ifdef VX_CACHE_FLUSH_PERF_EN
    , .perf_flush_evicts(pe_b), .perf_flush_cycles(pc_b)
`endif
  );
  assign big.flush_req_valid = 1'b0;
  assign big.mshr_empty      = 1'b1;
  assign big.flush_ready     = 1'b1;
  assign big.evict_fire      = 1'b0;
  assign big.mem_wr_ack      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_init(input int n);
    for (int k = 0; k < n; k++) begin
      chk("init_hi", 32'(sif.init), 1);
      chk("init_line", 32'(sif.init_line), k);
      step();
    end
    chk("ready_after_init", 32'(sif.flush_req_ready), 1);
  endtask

  // one full flush; expected commands come from a (line, way) queue built by plain loops
  task automatic do_flush(input int hold, input int rdy_pct, input int ev_pct,
                          input int ack_pct, input int abort_line);
    int q[$];
    int c, wc, stall;
    bit rdy, fire, ev, ack, zero_now;
    for (int l = 0; l < LPB; l++)
      for (int w = 0; w < NW; w++) q.push_back(l * NW + w);
    chk("idle_ready", 32'(sif.flush_req_ready), 1);
    chk("idle_busy", 32'(sif.busy), 0);
    chk("idle_block", 32'(sif.core_req_block), 0);
    sif.flush_req_valid = 1'b1;
    sif.mshr_empty = 1'b0;
    step();
    sif.flush_req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("drain_block", 32'(sif.core_req_block), 1);
      chk("drain_valid", 32'(sif.flush_valid), 0);
      step();
    end
    sif.mshr_empty = 1'b1;
    step();
    c = 0;
    stall = 0;
    while (q.size() > 0 && c < 300) begin
      c++;
      if (abort_line >= 0 && q[0] / NW == abort_line) begin
        reset = 1'b1;
        sif.flush_ready = 1'b0;
        sif.evict_fire = 1'b0;
        sif.mem_wr_ack = 1'b0;
        step();
        chk("rst_init", 32'(sif.init), 1);
        chk("rst_init_line", 32'(sif.init_line), 0);
        chk("rst_valid", 32'(sif.flush_valid), 0);
        chk("rst_busy", 32'(sif.busy), 1);
        reset = 1'b0;
        pend = 0;
        return;
      end
      chk("flush_valid", 32'(sif.flush_valid), 32'(pend != MAXP));
      chk("flush_line", 32'(sif.flush_line_sel), q[0] / NW);
      chk("flush_way", 32'(sif.flush_way_sel), 1 << (q[0] % NW));
      chk("flush_block", 32'(sif.core_req_block), 1);
      stall = pend == MAXP ? stall + 1 : 0;
      rdy  = $urandom_range(99) < rdy_pct;
      fire = rdy && pend != MAXP;
      ev   = fire && $urandom_range(99) < ev_pct;
      ack  = pend > 0 && (stall >= 3 || $urandom_range(99) < ack_pct);
      sif.flush_ready = rdy;
      sif.evict_fire = ev;
      sif.mem_wr_ack = ack;
      step();
      pend = pend + int'(ev) - int'(ack);
      if (fire) void'(q.pop_front());
    end
    sif.flush_ready = 1'b0;
    sif.evict_fire = 1'b0;
    sif.mem_wr_ack = 1'b0;
    chk("flush_cmds_left", q.size(), 0);
    if (q.size() > 0) return;
    wc = 0;
    do begin
      wc++;
      chk("wait_done", 32'(sif.flush_done), 0);
      chk("wait_valid", 32'(sif.flush_valid), 0);
      chk("wait_block", 32'(sif.core_req_block), 1);
      zero_now = pend == 0;
      ack = pend > 0 && $urandom_range(1) == 1;
      sif.mem_wr_ack = ack;
      step();
      pend -= int'(ack);
    end while (!zero_now && wc < 100);
    sif.mem_wr_ack = 1'b0;
    if (ev_pct == 0) chk("last_fire_to_done", wc, 1);
    chk("done_pulse", 32'(sif.flush_done), 1);
    chk("done_block", 32'(sif.core_req_block), 0);
    chk("done_ready", 32'(sif.flush_req_ready), 0);
    chk("done_busy", 32'(sif.busy), 1);
    sif.flush_req_valid = 1'b1;
    step();
    sif.flush_req_valid = 1'b0;
    chk("done_one_cycle", 32'(sif.flush_done), 0);
    chk("no_accept_in_done", 32'(sif.flush_req_ready), 1);
  endtask

  initial begin
    sif.flush_req_valid = 1'b0;
    sif.mshr_empty = 1'b1;
    sif.flush_ready = 1'b0;
    sif.evict_fire = 1'b0;
    sif.mem_wr_ack = 1'b0;
    step();
    step();
    chk("rst_init", 32'(sif.init), 1);
    chk("rst_block", 32'(sif.core_req_block), 1);
    chk("rst_busy", 32'(sif.busy), 1);
    chk("rst_ready", 32'(sif.flush_req_ready), 0);
    chk("rst_valid", 32'(sif.flush_valid), 0);
    chk("rst_done", 32'(sif.flush_done), 0);
    chk("rst_big_init", 32'(big.init), 1);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk("big_init", 32'(big.init), 1);
      chk("big_init_line", 32'(big.init_line), k);
      if (k < LPB) chk("small_init_line", 32'(sif.init_line), k);
      if (k == LPB) chk("small_ready", 32'(sif.flush_req_ready), 1);
      step();
    end
    chk("big_ready_cycle65", 32'(big.flush_req_ready), 1);
    chk("big_init_off", 32'(big.init), 0);
    do_flush(0, 100, 0, 0, -1);
    do_flush(10, 100, 0, 0, -1);
    do_flush(0, 100, 100, 0, -1);
    for (int r = 0; r < 8; r++)
      do_flush($urandom_range(3), 60, 70, 40, -1);
    do_flush(0, 100, 100, 0, 2);
    check_init(LPB);
    do_flush(0, 100, 0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
